// File: rtl/jtbubl_vtimer_gen.sv
// Video timing generator: H/V pixel counters with decoded blanking, sync,
// render-ahead line numbers, delayed blanking and a line interrupt.
module jtbubl_vtimer_gen #(
   parameter int W          = 9,
   parameter int HCNT_START = 0,
   parameter int HCNT_END   = 383,
   parameter int VCNT_START = 0,
   parameter int VCNT_END   = 263,
   parameter int HB_START   = 255,
   parameter int HB_END     = 383,
   parameter int HS_START   = 288,
   parameter int HS_END     = 319,
   parameter int VB_START   = 223,
   parameter int VB_END     = 263,
   parameter int VS_START   = 232,
   parameter int VS_END     = 235,
   parameter int AHEAD      = 1,
   parameter int DLY        = 4,
   parameter int IRQ_LINE   = 240
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pxl_cen,
   input  logic         flip,
   input  logic         irq_ack,
   output logic [W-1:0] hdump,
   output logic [W-1:0] vdump,
   output logic [W-1:0] vrender,
   output logic [W-1:0] vrender1,
   output logic         Hinit,
   output logic         Vinit,
   output logic         LHBL,
   output logic         LVBL,
   output logic         LHBL_dly,
   output logic         LVBL_dly,
   output logic         HS,
   output logic         VS,
   output logic         flip_q,
   output logic         irq_n
);

   localparam logic [W-1:0] L_HCS   = (W)'(HCNT_START);
   localparam logic [W-1:0] L_HCE   = (W)'(HCNT_END);
   localparam logic [W-1:0] L_VCS   = (W)'(VCNT_START);
   localparam logic [W-1:0] L_VCE   = (W)'(VCNT_END);
   localparam logic [W-1:0] L_HBS   = (W)'(HB_START);
   localparam logic [W-1:0] L_HBE   = (W)'(HB_END);
   localparam logic [W-1:0] L_HSS   = (W)'(HS_START);
   localparam logic [W-1:0] L_HSE   = (W)'(HS_END);
   localparam logic [W-1:0] L_VBS   = (W)'(VB_START);
   localparam logic [W-1:0] L_VBE   = (W)'(VB_END);
   localparam logic [W-1:0] L_VSS   = (W)'(VS_START);
   localparam logic [W-1:0] L_VSE   = (W)'(VS_END);
   localparam logic [W-1:0] L_IRQ   = (W)'(IRQ_LINE);
   localparam logic [W-1:0] L_ONE   = (W)'(1);
   localparam logic [W-1:0] L_FMASK = (W)'(255);
   localparam logic [W:0]   L_VSPAN = (W+1)'(VCNT_END - VCNT_START + 1);
   localparam logic [W:0]   L_AHEAD = (W+1)'(AHEAD);
   localparam logic [W:0]   L_WONE  = (W+1)'(1);

   logic [W-1:0] r_h;
   logic [W-1:0] r_v;

   logic         w_hWrap;
   logic         w_vWrap;
   logic [W-1:0] w_hNext;
   logic [W-1:0] w_vNext;
   logic         w_hInit;
   logic         w_vInit;
   logic         w_flipNext;
   logic [W-1:0] w_vRaw;
   logic [W-1:0] w_vRaw1;
   logic [W-1:0] w_flipMask;
   logic         w_irqSet;

   // Inclusive window test; a start above the end means the window wraps
   // through the counter end.
   function automatic logic inWin(input logic [W-1:0] x,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      if (a <= b) return (x >= a) && (x <= b);
      return (x >= a) || (x <= b);
   endfunction

   // Folds a line number that ran past the last line back into the V range;
   // the lead is small, so one subtraction is always enough.
   function automatic logic [W-1:0] wrapV(input logic [W:0] s);
      logic [W:0] t;
      t = (s > {1'b0, L_VCE}) ? s - L_VSPAN : s;
      return t[W-1:0];
   endfunction

   assign hdump = r_h;
   assign vdump = r_v;

   // Next counter values and everything decoded from them, so registered
   // outputs line up with the counters on the same strobe.
   always_comb begin
      w_hWrap    = (r_h == L_HCE);
      w_vWrap    = (r_v == L_VCE);
      w_hNext    = w_hWrap ? L_HCS : r_h + L_ONE;
      w_vNext    = r_v;
      if (w_hWrap) w_vNext = w_vWrap ? L_VCS : r_v + L_ONE;
      w_hInit    = (w_hNext == L_HCS);
      w_vInit    = w_hInit && (w_vNext == L_VCS);
      w_flipNext = w_vInit ? flip : flip_q;
      w_vRaw     = wrapV({1'b0, w_vNext} + L_AHEAD);
      w_vRaw1    = wrapV({1'b0, w_vRaw} + L_WONE);
      w_flipMask = w_flipNext ? L_FMASK : '0;
      w_irqSet   = pxl_cen && w_hInit && (w_vNext == L_IRQ);
   end

   // Counters and decoded video signals, all advancing on the pixel strobe.
   // Flip is only taken at the frame start so a frame never tears.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h      <= L_HCS;
         r_v      <= L_VCS;
         Hinit    <= 1'b0;
         Vinit    <= 1'b0;
         LHBL     <= 1'b0;
         LVBL     <= 1'b0;
         HS       <= 1'b0;
         VS       <= 1'b0;
         flip_q   <= 1'b0;
         vrender  <= '0;
         vrender1 <= '0;
      end else if (pxl_cen) begin
         r_h      <= w_hNext;
         r_v      <= w_vNext;
         Hinit    <= w_hInit;
         Vinit    <= w_vInit;
         LHBL     <= ~inWin(w_hNext, L_HBS, L_HBE);
         LVBL     <= ~inWin(w_vNext, L_VBS, L_VBE);
         HS       <= inWin(w_hNext, L_HSS, L_HSE);
         if (w_hWrap) VS <= inWin(w_vNext, L_VSS, L_VSE);
         flip_q   <= w_flipNext;
         vrender  <= w_vRaw ^ w_flipMask;
         vrender1 <= w_vRaw1 ^ w_flipMask;
      end
   end

   // Line interrupt: a new set beats a simultaneous acknowledge, and the
   // acknowledge itself is not tied to the pixel strobe.
   always_ff @(posedge clk) begin
      if (rst)           irq_n <= 1'b1;
      else if (w_irqSet) irq_n <= 1'b0;
      else if (irq_ack)  irq_n <= 1'b1;
   end

   generate
      if (DLY == 0) begin : g_noDly
         assign LHBL_dly = LHBL;
         assign LVBL_dly = LVBL;
      end else begin : g_dly
         logic [DLY-1:0] r_hDly;
         logic [DLY-1:0] r_vDly;

         // Blanking history shifted once per strobe; the tap at the far end
         // lags the live blanking by exactly DLY strobes.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_hDly <= '0;
               r_vDly <= '0;
            end else if (pxl_cen) begin
               r_hDly[0] <= LHBL;
               r_vDly[0] <= LVBL;
               for (int i = 1; i < DLY; i++) begin
                  r_hDly[i] <= r_hDly[i-1];
                  r_vDly[i] <= r_vDly[i-1];
               end
            end
         end

         assign LHBL_dly = r_hDly[DLY-1];
         assign LVBL_dly = r_vDly[DLY-1];
      end
   endgenerate

endmodule

// File: tb/tb_jtbubl_vtimer_gen.sv
// Bench for jtbubl_vtimer_gen: four builds (defaults, no blanking delay,
// wrapped H blanking, short lines) run in lockstep against a behavioural
// model whose expected outputs go through a scoreboard queue.
module tb_jtbubl_vtimer_gen;

   typedef struct packed {
      int hs, he, vs, ve, hbs, hbe, hss, hse, vbs, vbe, vss, vse, ahead, dly, irq;
   } cfg_t;

   typedef struct packed {
      int h, v, vr, vr1;
      logic lhbl, lvbl, hs, vs, hinit, vinit, flipq, irqn;
      logic [15:0] hHist, vHist;
   } mst_t;

   typedef logic [45:0] vec_t;
   typedef struct { vec_t v[4]; } exp_t;

   logic clock = 1'b0;
   logic reset;
   logic pxlCen;
   logic flip;
   logic irqAck;

   wire [8:0] hd[4];
   wire [8:0] vd[4];
   wire [8:0] vr[4];
   wire [8:0] vr1[4];
   wire [9:0] fo[4];

   cfg_t  cfg[4];
   mst_t  m[4];
   exp_t  sbq[$];
   string names[4] = '{"dflt", "dly0", "hwrap", "small"};
   int    checks = 0;
   int    errors = 0;
   int    stbCount = 0;
   int    vinitCount = 0;

   always #5 clock = ~clock;

   jtbubl_vtimer_gen dutA (
      .clk(clock), .rst(reset), .pxl_cen(pxlCen), .flip(flip), .irq_ack(irqAck),
      .hdump(hd[0]), .vdump(vd[0]), .vrender(vr[0]), .vrender1(vr1[0]),
      .Hinit(fo[0][9]), .Vinit(fo[0][8]), .LHBL(fo[0][7]), .LVBL(fo[0][6]),
      .LHBL_dly(fo[0][5]), .LVBL_dly(fo[0][4]), .HS(fo[0][3]), .VS(fo[0][2]),
      .flip_q(fo[0][1]), .irq_n(fo[0][0]));

   jtbubl_vtimer_gen #(.DLY(0)) dutB (
      .clk(clock), .rst(reset), .pxl_cen(pxlCen), .flip(flip), .irq_ack(irqAck),
      .hdump(hd[1]), .vdump(vd[1]), .vrender(vr[1]), .vrender1(vr1[1]),
      .Hinit(fo[1][9]), .Vinit(fo[1][8]), .LHBL(fo[1][7]), .LVBL(fo[1][6]),
      .LHBL_dly(fo[1][5]), .LVBL_dly(fo[1][4]), .HS(fo[1][3]), .VS(fo[1][2]),
      .flip_q(fo[1][1]), .irq_n(fo[1][0]));

   jtbubl_vtimer_gen #(.HB_START(370), .HB_END(10)) dutC (
      .clk(clock), .rst(reset), .pxl_cen(pxlCen), .flip(flip), .irq_ack(irqAck),
      .hdump(hd[2]), .vdump(vd[2]), .vrender(vr[2]), .vrender1(vr1[2]),
      .Hinit(fo[2][9]), .Vinit(fo[2][8]), .LHBL(fo[2][7]), .LVBL(fo[2][6]),
      .LHBL_dly(fo[2][5]), .LVBL_dly(fo[2][4]), .HS(fo[2][3]), .VS(fo[2][2]),
      .flip_q(fo[2][1]), .irq_n(fo[2][0]));

   jtbubl_vtimer_gen #(.HCNT_END(63), .HB_START(40), .HB_END(63),
                       .HS_START(48), .HS_END(55)) dutS (
      .clk(clock), .rst(reset), .pxl_cen(pxlCen), .flip(flip), .irq_ack(irqAck),
      .hdump(hd[3]), .vdump(vd[3]), .vrender(vr[3]), .vrender1(vr1[3]),
      .Hinit(fo[3][9]), .Vinit(fo[3][8]), .LHBL(fo[3][7]), .LVBL(fo[3][6]),
      .LHBL_dly(fo[3][5]), .LVBL_dly(fo[3][4]), .HS(fo[3][3]), .VS(fo[3][2]),
      .flip_q(fo[3][1]), .irq_n(fo[3][0]));

   function automatic logic win(int x, int a, int b);
      if (a <= b) return (x >= a) && (x <= b);
      return (x >= a) || (x <= b);
   endfunction

   // Behavioural model of one clk of the timing generator.
   function automatic mst_t step(mst_t s, cfg_t c, logic cen, logic fl, logic ack, logic rs);
      mst_t n;
      logic wrap;
      logic set;
      int   span, raw, raw1;
      n   = s;
      set = 1'b0;
      if (rs) begin
         n      = '0;
         n.h    = c.hs;
         n.v    = c.vs;
         n.irqn = 1'b1;
         return n;
      end
      if (cen) begin
         wrap = (s.h == c.he);
         n.h  = wrap ? c.hs : s.h + 1;
         if (wrap) n.v = (s.v == c.ve) ? c.vs : s.v + 1;
         n.hHist = {s.hHist[14:0], s.lhbl};
         n.vHist = {s.vHist[14:0], s.lvbl};
         n.lhbl  = !win(n.h, c.hbs, c.hbe);
         n.lvbl  = !win(n.v, c.vbs, c.vbe);
         n.hs    = win(n.h, c.hss, c.hse);
         if (wrap) n.vs = win(n.v, c.vss, c.vse);
         n.hinit = (n.h == c.hs);
         n.vinit = n.hinit && (n.v == c.vs);
         if (n.vinit) n.flipq = fl;
         span = c.ve - c.vs + 1;
         raw  = n.v + c.ahead;
         if (raw > c.ve) raw -= span;
         raw1 = raw + 1;
         if (raw1 > c.ve) raw1 -= span;
         n.vr  = n.flipq ? (raw ^ 255) : raw;
         n.vr1 = n.flipq ? (raw1 ^ 255) : raw1;
         set   = n.hinit && (n.v == c.irq);
      end
      if (set)      n.irqn = 1'b0;
      else if (ack) n.irqn = 1'b1;
      return n;
   endfunction

   function automatic vec_t pack(mst_t s, cfg_t c);
      logic hdl, vdl;
      if (c.dly == 0) begin
         hdl = s.lhbl;
         vdl = s.lvbl;
      end else begin
         hdl = s.hHist[c.dly-1];
         vdl = s.vHist[c.dly-1];
      end
      return {9'(s.h), 9'(s.v), 9'(s.vr), 9'(s.vr1), s.hinit, s.vinit, s.lhbl,
              s.lvbl, hdl, vdl, s.hs, s.vs, s.flipq, s.irqn};
   endfunction

   // One clk: drive inputs, queue the model's prediction, then compare every
   // build against it just after the edge.
   task automatic applyStimulus(input logic cen, input logic ack);
      exp_t e;
      vec_t o;
      pxlCen = cen;
      irqAck = ack;
      for (int k = 0; k < 4; k++) begin
         m[k]   = step(m[k], cfg[k], cen, flip, ack, reset);
         e.v[k] = pack(m[k], cfg[k]);
      end
      sbq.push_back(e);
      @(posedge clock);
      #1;
      e = sbq.pop_front();
      for (int k = 0; k < 4; k++) begin
         o = {hd[k], vd[k], vr[k], vr1[k], fo[k]};
         checks++;
         assert (o === e.v[k]) else begin
            errors++;
            $error("[TB] FAIL state_%s observed=%h expected=%h", names[k], o, e.v[k]);
         end
      end
      if (cen && !reset && fo[3][8]) vinitCount++;
      pxlCen = 1'b0;
      irqAck = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // A pixel strobe, with an idle clk slipped in now and then.
   task automatic pulse();
      stbCount++;
      if (stbCount % 5 == 4) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
   endtask

   task automatic guardExpired(input string tag, input int g);
      if (g >= 60000) begin
         errors++;
         $error("[TB] FAIL %s observed=timeout expected=reached", tag);
      end
   endtask

   initial begin
      int   g;
      int   lFall, dFall;
      logic pl, pd;

      reset  = 1'b0;
      pxlCen = 1'b0;
      flip   = 1'b0;
      irqAck = 1'b0;
      cfg[0] = '{hs:0, he:383, vs:0, ve:263, hbs:255, hbe:383, hss:288, hse:319,
                 vbs:223, vbe:263, vss:232, vse:235, ahead:1, dly:4, irq:240};
      cfg[1] = cfg[0];
      cfg[1].dly = 0;
      cfg[2] = cfg[0];
      cfg[2].hbs = 370;
      cfg[2].hbe = 10;
      cfg[3] = cfg[0];
      cfg[3].he  = 63;
      cfg[3].hbs = 40;
      cfg[3].hbe = 63;
      cfg[3].hss = 48;
      cfg[3].hse = 55;

      $display("[TB] reset");
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      reset = 1'b0;
      checkOutput("reset_hdump", hd[0], 0);
      checkOutput("reset_lhbl", fo[0][7], 0);
      checkOutput("reset_irq_n", fo[0][0], 1);
      checkOutput("reset_vrender", vr[0], 0);

      $display("[TB] first line");
      lFall = -1;
      dFall = -1;
      pl = fo[0][7];
      pd = fo[0][5];
      for (int i = 1; i <= 384; i++) begin
         pulse();
         if (pl && !fo[0][7] && lFall < 0) lFall = i;
         if (pd && !fo[0][5] && dFall < 0) dFall = i;
         pl = fo[0][7];
         pd = fo[0][5];
      end
      checkOutput("line_wrap_hdump", hd[0], 0);
      checkOutput("line_wrap_vdump", vd[0], 1);
      checkOutput("line_wrap_hinit", fo[0][9], 1);
      checkOutput("lhbl_fall_strobe", lFall, 255);
      checkOutput("lhbl_dly_lag", dFall - lFall, 4);
      checkOutput("hwrap_lhbl_at_h0", fo[2][7], 0);

      $display("[TB] flip request mid-frame");
      for (g = 0; g < 60000 && m[3].v != 100; g++) pulse();
      guardExpired("reach_v100", g);
      flip = 1'b1;
      pulse();
      checkOutput("flip_held", fo[3][1], 0);
      checkOutput("vrender_unflipped", vr[3], 101);

      $display("[TB] line interrupt");
      for (g = 0; g < 60000 && !(m[3].v == 240 && m[3].h == 0); g++) pulse();
      guardExpired("reach_irq", g);
      checkOutput("irq_set", fo[3][0], 0);
      checkOutput("irq_other_build", fo[0][0], 1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("irq_before_ack", fo[3][0], 0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("irq_after_ack", fo[3][0], 1);

      $display("[TB] render wrap and flipped frame");
      for (g = 0; g < 60000 && m[3].v != 263; g++) pulse();
      guardExpired("reach_v263", g);
      checkOutput("vrender_v263", vr[3], 0);
      checkOutput("vrender1_v263", vr1[3], 1);
      vinitCount = 0;
      for (g = 0; g < 60000 && m[3].v != 10; g++) pulse();
      guardExpired("reach_v10", g);
      checkOutput("vrender_flipped", vr[3], 9'h0F4);
      checkOutput("vrender1_flipped", vr1[3], 9'h0F3);
      checkOutput("flip_latched", fo[3][1], 1);
      checkOutput("vinit_per_frame", vinitCount, 1);
      flip = 1'b0;

      $display("[TB] ack on the set clk");
      for (g = 0; g < 60000 && !(m[3].v == 239 && m[3].h == 63); g++) pulse();
      guardExpired("reach_pre_irq", g);
      applyStimulus(1'b1, 1'b1);
      checkOutput("irq_set_wins", fo[3][0], 0);

      $display("[TB] reset mid-frame");
      for (g = 0; g < 60000 && m[0].v != 100; g++) pulse();
      guardExpired("reach_dflt_v100", g);
      checkOutput("irq_pending", fo[3][0], 0);
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0);
      reset = 1'b0;
      checkOutput("midreset_hdump", hd[0], 0);
      checkOutput("midreset_vdump", vd[0], 0);
      checkOutput("midreset_irq_dropped", fo[3][0], 1);
      for (int i = 0; i < 3; i++) pulse();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
